// File: rtl/reduce_result_fifo.sv
// rtl/reduce_result_fifo.sv - result queue behind reduce_sum with registered head and sticky drop status
// Optional RESULT_DROP_CNT_EN adds a saturating drop_count output.
module reduce_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     clr_ovf,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
`ifdef RESULT_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [DATA_W-1:0] r_out_data;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [PW-1:0]     w_rd_ptr_inc;
    logic [PW-1:0]     w_wr_ptr_inc;
    logic [LW-1:0]     w_level_nxt;
    logic [DATA_W-1:0] w_out_data_nxt;

    always_comb begin
        w_pop        = (r_level != '0) & out_ready;
        w_push       = in_valid & ((r_level < FULL_LVL) | w_pop);
        w_drop       = in_valid & ~w_push;
        w_rd_ptr_inc = r_rd_ptr + PW'(1);
        w_wr_ptr_inc = r_wr_ptr + PW'(1);

        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + ONE_LVL;
            2'b01:   w_level_nxt = r_level - ONE_LVL;
            default: w_level_nxt = r_level;
        endcase

        // The head register mirrors r_mem[r_rd_ptr]; it is refilled from the
        // next stored entry, or straight from in_data when the queue holds
        // nothing behind the current head.
        w_out_data_nxt = r_out_data;
        if (w_pop) begin
            if (r_level > ONE_LVL) begin
                w_out_data_nxt = r_mem[w_rd_ptr_inc];
            end else if (w_push) begin
                w_out_data_nxt = in_data;
            end
        end else if ((r_level == '0) && w_push) begin
            w_out_data_nxt = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_data <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_level    <= w_level_nxt;
            r_out_data <= w_out_data_nxt;
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef RESULT_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            if (clr_ovf) begin
                r_drop_count <= 16'd1;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end else if (clr_ovf) begin
            r_drop_count <= '0;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign out_data  = r_out_data;
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_reduce_result_fifo.sv
// tb/tb_reduce_result_fifo.sv - scoreboard bench for reduce_result_fifo (DEPTH=4, DATA_W=32)
module tb_reduce_result_fifo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              clr_ovf;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        level;
    logic              overflow;
`ifdef RESULT_DROP_CNT_EN
    logic [15:0]       drop_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] sb[$];
    logic m_ovf;

    always #5 clk = ~clk;

    reduce_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
`ifdef RESULT_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        m_ovf = 1'b0;
    endtask

    // One clock of stimulus; accepted words go into the scoreboard.
    task automatic drive(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                         input logic clr, output logic popped, output logic [DATA_W-1:0] got);
        in_valid = iv; in_data = id; out_ready = ordy; clr_ovf = clr;
        #1;
        popped = out_valid & ordy;
        got    = out_data;
        if (iv) begin
            if (sb.size() < DEPTH || popped) sb.push_back(id);
            else m_ovf = 1'b1;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        logic p; logic [DATA_W-1:0] g;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk); #1;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %0h want 0", out_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rst = 1'b1; sb.delete(); m_ovf = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0, p, g);
        total++; if (p !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL ready_when_empty: got pop=%b level=%0d want pop=0 level=0", p, level); end
    endtask

    task automatic test_single();
        logic p; logic [DATA_W-1:0] g, exp;
        do_reset();
        drive(1'b1, 32'h0000_0005, 1'b1, 1'b0, p, g);
        total++; if (p !== 1'b0) begin bad++; $display("FAIL single_no_fallthrough: got pop=%b want 0", p); end
        total++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin bad++; $display("FAIL single_head: got v=%b d=%0h want v=1 d=5", out_valid, out_data); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level1: got %0d want 1", level); end
        drive(1'b0, '0, 1'b1, 1'b0, p, g);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        total++; if (p !== 1'b1 || g !== exp) begin bad++; $display("FAIL single_pop: got pop=%b d=%0h want pop=1 d=%0h", p, g, exp); end
        total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_empty: got level=%0d v=%b want 0 0", level, out_valid); end
    endtask

    task automatic test_overflow();
        logic p; logic [DATA_W-1:0] g, exp;
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0, p, g);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`ifdef RESULT_DROP_CNT_EN
        total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL ovf_dropcnt: got %0d want 1", drop_count); end
`endif
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, p, g);
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            total++; if (p !== 1'b1 || g !== exp) begin bad++; $display("FAIL ovf_drain: got pop=%b d=%0h want pop=1 d=%0h", p, g, exp); end
        end
        total++; if (level !== 3'd0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_after_drain: got level=%0d ovf=%b want 0 1", level, overflow); end
    endtask

    task automatic test_full_pop();
        logic p; logic [DATA_W-1:0] g, exp;
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0, p, g);
        drive(1'b1, 32'h9, 1'b1, 1'b0, p, g);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        total++; if (p !== 1'b1 || g !== exp) begin bad++; $display("FAIL fullpop_head: got pop=%b d=%0h want pop=1 d=%0h", p, g, exp); end
        total++; if (level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL fullpop_level: got level=%0d ovf=%b want 4 0", level, overflow); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, p, g);
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            total++; if (p !== 1'b1 || g !== exp) begin bad++; $display("FAIL fullpop_drain: got pop=%b d=%0h want pop=1 d=%0h", p, g, exp); end
        end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL fullpop_empty: got %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        logic p; logic [DATA_W-1:0] g, exp, prev_data;
        logic prev_stall, iv, ordy;
        int n, pops;
        do_reset();
        n = 0; pops = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 60; c++) begin
            if (prev_stall && out_valid) begin
                total++; if (out_data !== prev_data) begin bad++; $display("FAIL wrap_stall_stable: got %0h want %0h", out_data, prev_data); end
            end
            iv   = (c % 2 == 0) && (n < 10);
            ordy = (c % 3 != 2);
            prev_stall = out_valid & ~ordy;
            prev_data  = out_data;
            drive(iv, 32'h100 + DATA_W'(n), ordy, 1'b0, p, g);
            if (iv) n++;
            if (p) begin
                pops++;
                exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                total++; if (g !== exp) begin bad++; $display("FAIL wrap_order: got %0h want %0h", g, exp); end
            end
        end
        total++; if (pops !== 10 || level !== 3'd0) begin bad++; $display("FAIL wrap_count: got pops=%0d level=%0d want 10 0", pops, level); end
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL wrap_ovf: got %b want %b", overflow, m_ovf); end
    endtask

    task automatic test_clr_ovf();
        logic p; logic [DATA_W-1:0] g, exp;
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0, p, g);
        drive(1'b1, 32'h6, 1'b0, 1'b1, p, g);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_with_drop: got %b want 1", overflow); end
`ifdef RESULT_DROP_CNT_EN
        total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL clr_with_drop_cnt: got %0d want 1", drop_count); end
`endif
        drive(1'b0, '0, 1'b0, 1'b1, p, g);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_alone: got %b want 0", overflow); end
`ifdef RESULT_DROP_CNT_EN
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL clr_alone_cnt: got %0d want 0", drop_count); end
`endif
        total++; if (level !== 3'd4) begin bad++; $display("FAIL clr_level: got %0d want 4", level); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, p, g);
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            total++; if (p !== 1'b1 || g !== exp) begin bad++; $display("FAIL clr_drain: got pop=%b d=%0h want pop=1 d=%0h", p, g, exp); end
        end
    endtask

    task automatic test_async_reset();
        logic p; logic [DATA_W-1:0] g, exp;
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b0, p, g);
        drive(1'b0, '0, 1'b1, 1'b0, p, g);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        total++; if (p !== 1'b1 || g !== exp) begin bad++; $display("FAIL arst_prepop: got pop=%b d=%0h want pop=1 d=%0h", p, g, exp); end
        total++; if (level !== 3'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL arst_prelevel: got level=%0d v=%b want 3 1", level, out_valid); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL arst_level: got level=%0d v=%b want 0 0", level, out_valid); end
        total++; if (out_data !== 32'h0 || overflow !== 1'b0) begin bad++; $display("FAIL arst_data_ovf: got d=%0h ovf=%b want 0 0", out_data, overflow); end
`ifdef RESULT_DROP_CNT_EN
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", drop_count); end
`endif
        sb.delete(); m_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 32'h7, 1'b0, 1'b0, p, g);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h7 || level !== 3'd1) begin bad++; $display("FAIL arst_first: got v=%b d=%0h level=%0d want 1 7 1", out_valid, out_data, level); end
        drive(1'b0, '0, 1'b1, 1'b0, p, g);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        total++; if (p !== 1'b1 || g !== exp) begin bad++; $display("FAIL arst_pop: got pop=%b d=%0h want pop=1 d=%0h", p, g, exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_clr_ovf();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
